// File: rtl/vcd_stream_reader.sv
// vcd_stream_reader: byte-serial value-change dump parser.
// Rebuilds timestamps and scalar signal values from an ASCII stream.
module vcd_stream_reader #(
    parameter int          TIME_W  = 32,
    parameter int          IDX_W   = 3,
    parameter logic [7:0]  ID_BASE = 8'h21
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [7:0]             in_data,
    output logic                   in_ready,
    output logic                   time_valid,
    input  logic                   time_ready,
    output logic [TIME_W-1:0]      time_value,
    output logic                   chg_valid,
    output logic [IDX_W-1:0]       chg_index,
    output logic                   chg_xz,
    output logic [(1<<IDX_W)-1:0]  sig_value,
    output logic                   err,
    output logic [2:0]             err_code
);

    localparam int SIG_NUM = 1 << IDX_W;
    localparam int PW      = TIME_W + 4;

    localparam logic [2:0] E_CHAR  = 3'd1;
    localparam logic [2:0] E_OVF   = 3'd2;
    localparam logic [2:0] E_EMPTY = 3'd3;
    localparam logic [2:0] E_ID    = 3'd4;
    localparam logic [2:0] E_BACK  = 3'd5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_TIME,
        S_VAL,
        S_SKIP
    } state_t;

    state_t              state_q, state_d;
    logic [TIME_W-1:0]   acc_q, acc_d;
    logic                dig_q, dig_d;
    logic                ovf_q, ovf_d;
    logic [TIME_W-1:0]   last_q, last_d;
    logic                bit_q, bit_d;
    logic                xz_q, xz_d;
    logic                tv_q, tv_d;
    logic [TIME_W-1:0]   tval_q, tval_d;
    logic                cv_q, cv_d;
    logic [IDX_W-1:0]    ci_q, ci_d;
    logic                cx_q, cx_d;
    logic [SIG_NUM-1:0]  sig_q, sig_d;
    logic                err_q, err_d;
    logic [2:0]          ec_q, ec_d;

    logic                accept;
    logic                is_ws;
    logic                is_dig;
    logic                is_val;
    logic [PW-1:0]       prod;
    logic                ovf_now;
    logic [8:0]          id_off;
    logic                id_ok;

    assign in_ready = !reset && (!tv_q || time_ready);
    assign accept   = in_valid && in_ready;

    // Byte classification and the next accumulator value.
    always_comb begin
        is_ws   = (in_data == 8'h20) || (in_data == 8'h09) ||
                  (in_data == 8'h0D) || (in_data == 8'h0A);
        is_dig  = (in_data >= 8'h30) && (in_data <= 8'h39);
        is_val  = (in_data == 8'h30) || (in_data == 8'h31) ||
                  (in_data == 8'h78) || (in_data == 8'h7A);
        prod    = ({4'b0, acc_q} * PW'(10)) + PW'(in_data[3:0]);
        ovf_now = |prod[PW-1:TIME_W];
        id_off  = {1'b0, in_data} - {1'b0, ID_BASE};
        id_ok   = id_off < 9'(SIG_NUM);
    end

    // Record parser: next state, accumulator and registered outputs.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dig_d   = dig_q;
        ovf_d   = ovf_q;
        last_d  = last_q;
        bit_d   = bit_q;
        xz_d    = xz_q;
        tv_d    = tv_q && !time_ready;
        tval_d  = tval_q;
        cv_d    = 1'b0;
        ci_d    = '0;
        cx_d    = 1'b0;
        sig_d   = sig_q;
        err_d   = 1'b0;
        ec_d    = 3'd0;
        if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_data == 8'h23) begin
                        state_d = S_TIME;
                        acc_d   = '0;
                        dig_d   = 1'b0;
                        ovf_d   = 1'b0;
                    end else if (is_val) begin
                        state_d = S_VAL;
                        bit_d   = (in_data == 8'h31);
                        xz_d    = in_data[6];
                    end else if (!is_ws) begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                        ec_d    = E_CHAR;
                    end
                end
                S_TIME: begin
                    if (is_dig) begin
                        dig_d = 1'b1;
                        if (ovf_now) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                            if (!ovf_q) begin
                                err_d = 1'b1;
                                ec_d  = E_OVF;
                            end
                        end else begin
                            acc_d = prod[TIME_W-1:0];
                        end
                    end else if (is_ws) begin
                        state_d = S_IDLE;
                        if (!dig_q) begin
                            err_d = 1'b1;
                            ec_d  = E_EMPTY;
                        end else if (acc_q < last_q) begin
                            err_d = 1'b1;
                            ec_d  = E_BACK;
                        end else begin
                            tv_d   = 1'b1;
                            tval_d = acc_q;
                            last_d = acc_q;
                        end
                    end else begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                        ec_d    = E_CHAR;
                    end
                end
                S_VAL: begin
                    if (id_ok) begin
                        state_d = S_IDLE;
                        sig_d[id_off[IDX_W-1:0]] = bit_q & ~xz_q;
                        cv_d    = 1'b1;
                        ci_d    = id_off[IDX_W-1:0];
                        cx_d    = xz_q;
                    end else begin
                        state_d = S_SKIP;
                        err_d   = 1'b1;
                        ec_d    = E_ID;
                    end
                end
                S_SKIP: begin
                    if (in_data == 8'h0A) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and output registers; reset drops any partial record.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            dig_q   <= 1'b0;
            ovf_q   <= 1'b0;
            last_q  <= '0;
            bit_q   <= 1'b0;
            xz_q    <= 1'b0;
            tv_q    <= 1'b0;
            tval_q  <= '0;
            cv_q    <= 1'b0;
            ci_q    <= '0;
            cx_q    <= 1'b0;
            sig_q   <= '0;
            err_q   <= 1'b0;
            ec_q    <= 3'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            bit_q   <= bit_d;
            xz_q    <= xz_d;
            tv_q    <= tv_d;
            tval_q  <= tval_d;
            cv_q    <= cv_d;
            ci_q    <= ci_d;
            cx_q    <= cx_d;
            sig_q   <= sig_d;
            err_q   <= err_d;
            ec_q    <= ec_d;
        end
    end

    assign time_valid = tv_q;
    assign time_value = tval_q;
    assign chg_valid  = cv_q;
    assign chg_index  = ci_q;
    assign chg_xz     = cx_q;
    assign sig_value  = sig_q;
    assign err        = err_q;
    assign err_code   = ec_q;

endmodule

// File: tb/tb_vcd_stream_reader.sv
// tb_vcd_stream_reader: directed byte vectors with expected events,
// plus hand sequences for backpressure and mid-record reset.
module tb_vcd_stream_reader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        time_valid;
    logic        time_ready = 1'b1;
    logic [31:0] time_value;
    logic        chg_valid;
    logic [2:0]  chg_index;
    logic        chg_xz;
    logic [7:0]  sig_value;
    logic        err;
    logic [2:0]  err_code;

    int checks = 0;
    int errors = 0;

    localparam int KN = 0;
    localparam int KT = 1;
    localparam int KC = 2;
    localparam int KE = 3;
    localparam logic [7:0] LF = 8'h0A;

    typedef struct {
        logic [7:0]  b;
        int          k;
        logic [31:0] v;
        logic [7:0]  sig;
    } vec_t;

    vec_t tab[$];

    vcd_stream_reader #(
        .TIME_W (32),
        .IDX_W  (3),
        .ID_BASE(8'h21)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .time_valid(time_valid),
        .time_ready(time_ready),
        .time_value(time_value),
        .chg_valid (chg_valid),
        .chg_index (chg_index),
        .chg_xz    (chg_xz),
        .sig_value (sig_value),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [7:0] b, input int k,
                                input logic [31:0] v, input logic [7:0] s);
        vec_t t;
        t.b = b;
        t.k = k;
        t.v = v;
        t.sig = s;
        tab.push_back(t);
    endfunction

    function automatic void addn(input string str, input logic [7:0] s);
        for (int i = 0; i < str.len(); i++) add(str[i], KN, 0, s);
    endfunction

    task automatic send(input logic [7:0] b, input logic tr);
        @(negedge clock);
        in_valid   = 1'b1;
        in_data    = b;
        time_ready = tr;
        @(posedge clock);
        #1;
    endtask

    initial begin
        addn("1", 8'h00);
        add(")", KE, 4, 8'h00);
        addn("\n#3", 8'h00);
        add(LF, KT, 3, 8'h00);
        addn("#10", 8'h00);
        add(LF, KT, 10, 8'h00);
        addn("1", 8'h00);
        add("!", KC, 0, 8'h01);
        addn("0", 8'h01);
        add(8'h22, KC, 1, 8'h01);
        addn("z", 8'h01);
        add("#", KC, 10, 8'h01);
        addn("\n#", 8'h01);
        add(LF, KE, 3, 8'h01);
        addn("1", 8'h01);
        add("(", KC, 7, 8'h81);
        addn("x", 8'h81);
        add("$", KC, 11, 8'h81);
        addn("1", 8'h81);
        add("$", KC, 3, 8'h89);
        addn("0", 8'h89);
        add("!", KC, 0, 8'h88);
        addn("#20", 8'h88);
        add(LF, KT, 20, 8'h88);
        addn("#7", 8'h88);
        add(LF, KE, 5, 8'h88);
        addn("#20", 8'h88);
        add(LF, KT, 20, 8'h88);
        add("q", KE, 1, 8'h88);
        addn("a\n", 8'h88);
        addn("#1", 8'h88);
        add("a", KE, 1, 8'h88);
        addn("b\n \t", 8'h88);
        add(8'h0D, KN, 0, 8'h88);
        addn("#429496729", 8'h88);
        add("6", KE, 2, 8'h88);
        add(LF, KT, 32'hFFFF_FFFF, 8'h88);
        addn("#4294967295", 8'h88);
        add(LF, KT, 32'hFFFF_FFFF, 8'h88);
        addn("#999999999", 8'h88);
        add("9", KE, 2, 8'h88);
        addn("9", 8'h88);
        add(LF, KT, 32'hFFFF_FFFF, 8'h88);
        addn("#5", 8'h88);
        add(" ", KE, 5, 8'h88);

        #12;
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_time_valid", 32'(time_valid), 0);
        chk("rst_time_value", time_value, 0);
        chk("rst_chg_valid", 32'(chg_valid), 0);
        chk("rst_sig", 32'(sig_value), 0);
        chk("rst_err", 32'(err), 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);

        foreach (tab[i]) begin
            send(tab[i].b, 1'b1);
            chk($sformatf("v%0d_tv", i), 32'(time_valid),
                32'(tab[i].k == KT));
            if (tab[i].k == KT)
                chk($sformatf("v%0d_tval", i), time_value, tab[i].v);
            chk($sformatf("v%0d_cv", i), 32'(chg_valid),
                32'(tab[i].k == KC));
            if (tab[i].k == KC)
                chk($sformatf("v%0d_chg", i), {28'b0, chg_xz, chg_index},
                    tab[i].v);
            chk($sformatf("v%0d_err", i), 32'(err), 32'(tab[i].k == KE));
            if (tab[i].k == KE)
                chk($sformatf("v%0d_code", i), 32'(err_code), tab[i].v);
            chk($sformatf("v%0d_sig", i), 32'(sig_value), 32'(tab[i].sig));
        end

        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;

        send("#", 1'b0);
        send("5", 1'b0);
        send(LF, 1'b0);
        chk("bp_tv", 32'(time_valid), 1);
        chk("bp_tval", time_value, 5);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            in_valid   = 1'b1;
            in_data    = "#";
            time_ready = 1'b0;
            #1;
            chk($sformatf("bp_ready%0d", c), 32'(in_ready), 0);
            @(posedge clock);
            #1;
            chk($sformatf("bp_hold_tv%0d", c), 32'(time_valid), 1);
            chk($sformatf("bp_hold_val%0d", c), time_value, 5);
        end
        @(negedge clock);
        time_ready = 1'b1;
        #1;
        chk("bp_ready_hs", 32'(in_ready), 1);
        @(posedge clock);
        #1;
        chk("bp_cleared", 32'(time_valid), 0);
        send("6", 1'b1);
        send(LF, 1'b1);
        chk("bp_next_tv", 32'(time_valid), 1);
        chk("bp_next_val", time_value, 6);

        send("1", 1'b1);
        send("!", 1'b1);
        chk("mr_sig_set", 32'(sig_value), 1);
        send("#", 1'b1);
        send("1", 1'b1);
        send("2", 1'b1);
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mr_sig", 32'(sig_value), 0);
        chk("mr_in_ready", 32'(in_ready), 0);
        chk("mr_tv", 32'(time_valid), 0);
        chk("mr_tval", time_value, 0);
        @(negedge clock);
        reset = 1'b0;
        send(LF, 1'b1);
        chk("mr_no_emit", 32'(time_valid), 0);
        chk("mr_no_err", 32'(err), 0);
        send("#", 1'b1);
        send("1", 1'b1);
        send(LF, 1'b1);
        chk("mr_last_cleared", 32'(time_valid), 1);
        chk("mr_last_val", time_value, 1);

        @(negedge clock);
        in_valid = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
